// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch front-end.
package fetch_unit_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int INST_BYTES = WORD_WIDTH / 8;
  localparam logic [WORD_WIDTH-1:0] DEFAULT_RESET_PC = '0;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: redirect input, imem req/gnt/rvalid port and decoder valid/ready port.
interface fetch_unit_if #(
  parameter int W = 32
);
  logic         branch_take;
  logic [W-1:0] targ_pc;

  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;

  logic         inst_valid;
  logic [W-1:0] inst;
  logic [W-1:0] inst_pc;
  logic         inst_ready;

  modport master (
    input  branch_take, targ_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    output branch_take, targ_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous queue with push/pop/flush; flush wins over push and pop.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: credit-limited sequential fetch, response queue, redirect flush.
// Optional perf counters when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int           W        = WORD_WIDTH,
  parameter int           DEPTH    = 4,
  parameter int           MAX_OUT  = 2,
  parameter logic [W-1:0] RESET_PC = W'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_discarded
`endif
);

  localparam int INC = W / 8;
  localparam int CW  = cnt_w(DEPTH);
  localparam int OW  = cnt_w(MAX_OUT);

  if (!(W == 32 || W == 64) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      MAX_OUT < 1 || MAX_OUT > DEPTH) begin : g_bad_param
    $error("fetch_unit: illegal parameter combination");
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] pc;
  } entry_t;

  logic [W-1:0]  fetch_pc, resp_pc, targ_al;
  logic [OW-1:0] outstanding, discard;
  logic [CW-1:0] count;
  logic          credit_ok, xfer, drop, push, pop, full, empty;
  entry_t        wr_entry, rd_entry;

  assign targ_al = bus.targ_pc & ~W'(INC - 1);

  // Queue slots are reserved at request time, so every response has a home.
  assign credit_ok = (int'(count) + int'(outstanding) < DEPTH) &&
                     (int'(outstanding) < MAX_OUT);

  assign bus.imem_req  = rst && !bus.branch_take && credit_ok;
  assign bus.imem_addr = fetch_pc;
  assign xfer          = bus.imem_req && bus.imem_gnt;

  // A redirect cycle drops its response, so it counts as stale too.
  assign drop = bus.imem_rvalid && (discard != '0 || bus.branch_take);
  assign push = bus.imem_rvalid && discard == '0 && !bus.branch_take;
  assign pop  = bus.inst_valid && bus.inst_ready && !bus.branch_take;

  assign wr_entry = '{data: bus.imem_rdata, pc: resp_pc};

  assign bus.inst_valid = !empty;
  assign bus.inst       = empty ? '0 : rd_entry.data;
  assign bus.inst_pc    = empty ? '0 : rd_entry.pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (bus.branch_take) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc    <= targ_al;
      resp_pc     <= targ_al;
      outstanding <= outstanding - OW'(bus.imem_rvalid);
      discard     <= outstanding - OW'(bus.imem_rvalid);
    end else begin
      if (xfer) fetch_pc <= fetch_pc + W'(INC);
      if (push) resp_pc  <= resp_pc + W'(INC);
      outstanding <= outstanding + OW'(xfer) - OW'(bus.imem_rvalid);
      if (drop) discard <= discard - OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.branch_take),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (pop)  perf_fetched   <= perf_fetched + 32'd1;
      if (drop) perf_discarded <= perf_discarded + 32'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && full && !pop));
  a_out_limit: assert property (@(posedge clk) disable iff (!rst)
    int'(outstanding) <= MAX_OUT);
  a_credit_limit: assert property (@(posedge clk) disable iff (!rst)
    int'(count) + int'(outstanding) <= DEPTH);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: epoch-tagged memory model plus decoder-side monitor.
module tb_fetch_unit;
  localparam int          W        = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.W(W)) bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  fetch_unit #(.W(W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    , .perf_fetched   (perf_fetched)
    , .perf_discarded (perf_discarded)
`endif
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  req_t pend[$];
  exp_t exp_q[$];
  int   epoch = 0, cyc = 0, last_due = 0;
  int   n_chk = 0, n_fail = 0;
  int   vis_cnt = 0, vis_out = 0, vis_disc = 0, disc_cnt = 0, fetched_cnt = 0;
  logic [31:0] next_fetch = RESET_PC;
  bit   in_rst = 1'b1, br_req = 1'b0;
  logic [31:0] br_targ = '0;
  int   p_gnt = 100, p_ready = 100, p_branch = 0, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #4;
  endtask

  // Memory + redirect driver; pushes the responses the decoder must eventually see.
  initial begin
    bit   br;
    int   lat;
    req_t r;
    bus.branch_take = 1'b0; bus.targ_pc = '0; bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        bus.branch_take = 1'b0; bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0; bus.inst_ready = 1'b0;
        continue;
      end
      cyc++;
      vis_cnt  = exp_q.size();
      vis_out  = pend.size();
      vis_disc = disc_cnt;
      br = br_req || ($urandom_range(99) < 32'(p_branch));
      bus.targ_pc     = br_req ? br_targ : $urandom;
      br_req          = 1'b0;
      bus.branch_take = br;
      bus.inst_ready  = ($urandom_range(99) < 32'(p_ready));
      bus.imem_gnt    = ($urandom_range(99) < 32'(p_gnt));
      bus.imem_rvalid = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_data(r.addr);
        if (!br && r.epoch == epoch) exp_q.push_back('{r.addr, mem_data(r.addr)});
        else disc_cnt++;
      end
      #1;
      if (bus.imem_req && bus.imem_gnt) begin
        lat = int'($urandom_range(32'(lat_max), 32'(lat_min)));
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        pend.push_back('{bus.imem_addr, epoch, last_due});
        check("outstanding_limit", 64'(pend.size() <= MAX_OUT), 64'(1));
      end
      if (br) begin
        exp_q.delete();
        epoch++;
      end
    end
  end

  // Decoder-side monitor: compares the queue head and request port against the model.
  initial begin
    exp_t e;
    bit   exp_req;
    forever begin
      @(negedge clk);
      #2;
      if (in_rst) continue;
      check("inst_valid", 64'(bus.inst_valid), 64'(vis_cnt != 0));
      if (!bus.inst_valid) begin
        check("inst_empty", 64'(bus.inst), 64'(0));
        check("inst_pc_empty", 64'(bus.inst_pc), 64'(0));
      end
      exp_req = !bus.branch_take && vis_out < MAX_OUT && vis_cnt + vis_out < DEPTH;
      check("imem_req", 64'(bus.imem_req), 64'(exp_req));
      if (bus.imem_req) check("imem_addr", 64'(bus.imem_addr), 64'(next_fetch));
`ifdef FETCH_PERF_EN
      check("perf_fetched", 64'(perf_fetched), 64'(fetched_cnt));
      check("perf_discarded", 64'(perf_discarded), 64'(vis_disc));
`endif
      if (bus.inst_valid && bus.inst_ready && !bus.branch_take) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_inst: got pc %0h, expected no instruction", bus.inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", 64'(bus.inst_pc), 64'(e.pc));
          check("inst", 64'(bus.inst), 64'(e.data));
          fetched_cnt++;
        end
      end
      if (bus.branch_take) next_fetch = bus.targ_pc & ~32'h3;
      else if (bus.imem_req && bus.imem_gnt) next_fetch = next_fetch + 32'd4;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int  snap, snap_perf;
    bit  found;
    #23;
    check("rst_imem_req", 64'(bus.imem_req), 64'(0));
    check("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
    check("rst_inst", 64'(bus.inst), 64'(0));
    check("rst_inst_pc", 64'(bus.inst_pc), 64'(0));
    check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));
    @(negedge clk); #3;
    rst = 1'b1; in_rst = 1'b0;

    // Streaming: full grant, 1-cycle latency, decoder always ready.
    wait_cyc(20);
    check("stream_progress", 64'(fetched_cnt >= 10), 64'(1));

    // Backpressure: queue fills to DEPTH and requests stop.
    p_ready = 0;
    wait_cyc(12);
    check("fill_count", 64'(exp_q.size()), 64'(DEPTH));
    check("fill_req_low", 64'(bus.imem_req), 64'(0));
    check("fill_outstanding", 64'(pend.size()), 64'(0));
    check("fill_valid", 64'(bus.inst_valid), 64'(1));
    p_ready = 100;
    wait_cyc(6);

    // Grant stall: request must hold.
    p_gnt = 0;
    wait_cyc(3);
    check("stall_req", 64'(bus.imem_req), 64'(1));
    check("stall_addr", 64'(bus.imem_addr), 64'(next_fetch));
    p_gnt = 100;

    // Redirect with two long-latency requests in flight.
    lat_min = 5; lat_max = 5;
    for (int i = 0; i < 50 && pend.size() != 2; i++) wait_cyc(1);
    check("two_outstanding", 64'(pend.size()), 64'(2));
    snap = disc_cnt;
`ifdef FETCH_PERF_EN
    snap_perf = int'(perf_discarded);
`else
    snap_perf = 0;
`endif
    br_targ = 32'h0000_0103; br_req = 1'b1;
    wait_cyc(15);
    check("redirect_stale", 64'(disc_cnt - snap), 64'(2));
`ifdef FETCH_PERF_EN
    check("perf_redirect_drops", 64'(int'(perf_discarded) - snap_perf), 64'(2));
`endif

    // Redirect landing on the same edge as a response and a pop.
    lat_min = 2; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      wait_cyc(1);
      if (pend.size() != 0 && pend[0].due <= cyc + 1 && exp_q.size() != 0) begin
        found = 1'b1;
        br_targ = 32'h0000_0400; br_req = 1'b1;
      end
    end
    check("coincide_found", 64'(found), 64'(1));
    wait_cyc(12);

    // Address wrap at 2^32.
    lat_min = 1; lat_max = 1;
    br_targ = 32'hFFFF_FFF8; br_req = 1'b1;
    snap = fetched_cnt;
    wait_cyc(10);
    check("wrap_progress", 64'(fetched_cnt - snap >= 4), 64'(1));

    // Random traffic.
    p_gnt = 70; p_ready = 70; p_branch = 4; lat_min = 1; lat_max = 6;
    snap = fetched_cnt;
    wait_cyc(3000);
    check("random_progress", 64'(fetched_cnt - snap > 200), 64'(1));

    // Asynchronous reset in the middle of a burst.
    p_branch = 0; p_gnt = 100; p_ready = 50; lat_min = 1; lat_max = 3;
    wait_cyc(10);
    #2;
    rst = 1'b0; in_rst = 1'b1;
    #1;
    check("arst_imem_req", 64'(bus.imem_req), 64'(0));
    check("arst_inst_valid", 64'(bus.inst_valid), 64'(0));
    check("arst_inst", 64'(bus.inst), 64'(0));
    check("arst_inst_pc", 64'(bus.inst_pc), 64'(0));
`ifdef FETCH_PERF_EN
    check("arst_perf_fetched", 64'(perf_fetched), 64'(0));
    check("arst_perf_discarded", 64'(perf_discarded), 64'(0));
`endif
    pend.delete(); exp_q.delete(); epoch++;
    next_fetch = RESET_PC; fetched_cnt = 0; disc_cnt = 0; last_due = 0;
    @(negedge clk); #3;
    rst = 1'b1; in_rst = 1'b0;
    p_ready = 100;
    wait_cyc(30);
    check("post_reset_progress", 64'(fetched_cnt >= 10), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction fetch front-end for the pipelined core, replacing the free-running PC register used by the single-cycle core.
- Issues sequential requests to a variable-latency instruction memory through a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to the decoder with valid/ready.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
W, 32, word width in bits; must be 32 or 64.
DEPTH, 4, fetch queue entries; a power of two, at least 2.
MAX_OUT, 2, maximum outstanding memory requests; 1..DEPTH.
RESET_PC, 0, fetch address after reset; W bits, word aligned.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
branch_take  in  1  redirect request, sampled each cycle
targ_pc  in  W  redirect target
imem_req  out  1  request valid
imem_addr  out  W  request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  one-cycle response pulse, in order, no backpressure
imem_rdata  in  W  response data
inst_valid  out  1  queue head valid
inst  out  W  queue head instruction
inst_pc  out  W  PC of inst
inst_ready  in  1  decoder accepts head

Behaviour:
- Reset (rst low, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue count=0, outstanding=0, discard=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- Step: INC=W/8. All PC arithmetic wraps modulo 2^W. targ_pc low log2(INC) bits are forced to 0.
- Request issue:
  - imem_req = !branch_take && (count+outstanding < DEPTH) && (outstanding < MAX_OUT).
  - imem_addr = fetch_pc.
  - A transfer occurs when imem_req && imem_gnt; fetch_pc then advances by INC.
  - While imem_req is high and not granted, imem_addr holds. The request may only be withdrawn by a redirect.
- Response handling:
  - On imem_rvalid, outstanding decrements.
  - If discard>0: data dropped, discard decrements.
  - Otherwise {imem_rdata, resp_pc} is pushed and resp_pc advances by INC.
  - The credit rule guarantees space. A push into a full queue is an assertion failure.
- Output:
  - inst_valid = count!=0.
  - inst and inst_pc come from the queue head and are 0 when the queue is empty.
  - Pop occurs on inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - First instruction appears no earlier than 1 cycle after rvalid, because the queue is registered.
- Redirect cycle (branch_take=1):
  - No request is issued, and any pop or push that cycle is ignored.
  - Next edge: count=0, fetch_pc=targ_pc, resp_pc=targ_pc.
  - outstanding = outstanding - imem_rvalid, and discard is set to that same value.
  - Result: every stale response, including those already marked discard, is dropped exactly once.
- Back-to-back redirects: each one recomputes discard as above. The last target wins.
- Outstanding limit: outstanding never exceeds MAX_OUT, and count+outstanding never exceeds DEPTH.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched (32 bits, counts instructions popped) and perf_discarded (32 bits, counts responses dropped).
  - Both are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/defines: WORD_WIDTH, INST_BYTES, default RESET_PC, and a clog2 helper constant for DEPTH and MAX_OUT counters.
- One sub-module, fetch_fifo:
  - Synchronous DEPTH x 2W queue with push, pop and flush, plus count/full/empty.
  - Pointers wrap modulo DEPTH.
  - Flush has priority over push and pop.

Test Plan:
- Reset then constant imem_gnt=1, 1-cycle rvalid latency, inst_ready=1, W=32 -> imem_addr 0x0,0x4,0x8...; inst_pc 0x0,0x4,0x8 in order with matching inst.
- inst_ready=0 with DEPTH=4 -> exactly 4 entries fill, imem_req drops. Then ready=1 -> entries drain in order and requests resume at 0x10.
- imem_gnt held 0 for 3 cycles -> imem_req=1, imem_addr=0x0 stable. Grant on cycle 4 -> fetch_pc becomes 0x4.
- MAX_OUT=2, 5-cycle latency, redirect to 0x100 with 2 outstanding -> both stale responses dropped (perf_discarded=2 with FETCH_PERF_EN). Next inst_pc=0x100.
- Redirect coinciding with imem_rvalid and a pop -> response dropped, discard=outstanding-1, count=0 next cycle, no duplicate or lost PC.
- RESET_PC=0xFFFFFFFC sequence -> inst_pc 0xFFFFFFFC then 0x0 (wrap). Async rst low mid-burst -> all outputs 0 immediately.
